// File: rtl/iq_mdu.sv
// Issue queue for the multiply/divide pipe. Holds renamed micro-ops in age
// order and issues the oldest one whose sources have both been produced.
module iq_mdu #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_back,
  input  logic            enq_valid,
  input  logic [5:0]      enq_Pj,
  input  logic [5:0]      enq_Pk,
  input  logic [5:0]      enq_Pd,
  input  logic            enq_rdy_j,
  input  logic            enq_rdy_k,
  input  logic [3:0]      enq_Conf,
  input  logic            enq_RegWr,
  input  logic [5:0]      enq_tag_rob,
  output logic            full_iq,
  input  logic [4:0]      ready_cdb,
  input  logic [4:0]      RegWr_cdb,
  input  logic [4:0][5:0] Pd_cdb,
  output logic            ready_mdu,
  output logic [5:0]      Pj_mdu,
  output logic [5:0]      Pk_mdu,
  output logic [5:0]      Pd_mdu,
  output logic [3:0]      Conf_mdu,
  output logic            RegWr_mdu,
  output logic [5:0]      tag_rob_mdu
);

  typedef struct packed {
    logic [5:0] Pj;
    logic [5:0] Pk;
    logic [5:0] Pd;
    logic       rdy_j;
    logic       rdy_k;
    logic [3:0] Conf;
    logic       RegWr;
    logic [5:0] tag_rob;
  } entry_t;

  entry_t           entry_q [DEPTH];
  entry_t           entry_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic             found;
  logic [CNT_W-1:0] sel;
  entry_t           sel_e;
  logic             accept;
  logic [CNT_W-1:0] tail;
  logic [4:0]       hit_v;
  entry_t           new_e;

  function automatic logic cdb_hit(input logic [5:0] tag, input logic [4:0] hv,
                                   input logic [4:0][5:0] pd);
    logic h;
    h = 1'b0;
    for (int unsigned p = 0; p < 5; p++) begin
      if (hv[p] && pd[p] == tag) h = 1'b1;
    end
    return h;
  endfunction

  assign hit_v   = ready_cdb & RegWr_cdb;
  assign full_iq = (count_q == CNT_W'(DEPTH));
  assign accept  = enq_valid & ~full_iq & ~flush_back;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    sel_e = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && i < 32'(count_q) && entry_q[i].rdy_j && entry_q[i].rdy_k) begin
        found = 1'b1;
        sel   = CNT_W'(i);
        sel_e = entry_q[i];
      end
    end
  end

  assign ready_mdu   = found;
  assign Pj_mdu      = sel_e.Pj;
  assign Pk_mdu      = sel_e.Pk;
  assign Pd_mdu      = sel_e.Pd;
  assign Conf_mdu    = sel_e.Conf;
  assign RegWr_mdu   = sel_e.RegWr;
  assign tag_rob_mdu = sel_e.tag_rob;

  always_comb begin
    new_e         = '0;
    new_e.Pj      = enq_Pj;
    new_e.Pk      = enq_Pk;
    new_e.Pd      = enq_Pd;
    new_e.rdy_j   = enq_rdy_j | cdb_hit(enq_Pj, hit_v, Pd_cdb);
    new_e.rdy_k   = enq_rdy_k | cdb_hit(enq_Pk, hit_v, Pd_cdb);
    new_e.Conf    = enq_Conf;
    new_e.RegWr   = enq_RegWr;
    new_e.tag_rob = enq_tag_rob;
    tail          = count_q - CNT_W'(found);
    count_d       = count_q + CNT_W'(accept) - CNT_W'(found);

    // Collapse above the issued slot, then wake the shifted copies, then
    // append at the post-shift tail so the new entry sees this cycle's CDB.
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      entry_d[i] = (found && i >= 32'(sel)) ? entry_q[i+1] : entry_q[i];
    end
    entry_d[DEPTH-1] = found ? '0 : entry_q[DEPTH-1];

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (cdb_hit(entry_d[i].Pj, hit_v, Pd_cdb)) entry_d[i].rdy_j = 1'b1;
      if (cdb_hit(entry_d[i].Pk, hit_v, Pd_cdb)) entry_d[i].rdy_k = 1'b1;
      if (accept && i == 32'(tail)) entry_d[i] = new_e;
    end

    if (flush_back) begin
      count_d = '0;
      for (int unsigned i = 0; i < DEPTH; i++) entry_d[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
    end
  end

endmodule

// File: tb/tb_iq_mdu.sv
// Bench for iq_mdu: directed vector table, hand-written corner sequences and
// random traffic, all checked against an age-ordered queue model.
module tb_iq_mdu;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush_back = 1'b0;
  logic            enq_valid = 1'b0;
  logic [5:0]      enq_Pj = '0, enq_Pk = '0, enq_Pd = '0;
  logic            enq_rdy_j = 1'b0, enq_rdy_k = 1'b0;
  logic [3:0]      enq_Conf = '0;
  logic            enq_RegWr = 1'b0;
  logic [5:0]      enq_tag_rob = '0;
  logic            full_iq;
  logic [4:0]      ready_cdb = '0, RegWr_cdb = '0;
  logic [4:0][5:0] Pd_cdb = '0;
  logic            ready_mdu;
  logic [5:0]      Pj_mdu, Pk_mdu, Pd_mdu;
  logic [3:0]      Conf_mdu;
  logic            RegWr_mdu;
  logic [5:0]      tag_rob_mdu;

  int checks = 0;
  int errors = 0;

  iq_mdu #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_back(flush_back), .enq_valid(enq_valid),
    .enq_Pj(enq_Pj), .enq_Pk(enq_Pk), .enq_Pd(enq_Pd),
    .enq_rdy_j(enq_rdy_j), .enq_rdy_k(enq_rdy_k), .enq_Conf(enq_Conf),
    .enq_RegWr(enq_RegWr), .enq_tag_rob(enq_tag_rob), .full_iq(full_iq),
    .ready_cdb(ready_cdb), .RegWr_cdb(RegWr_cdb), .Pd_cdb(Pd_cdb),
    .ready_mdu(ready_mdu), .Pj_mdu(Pj_mdu), .Pk_mdu(Pk_mdu), .Pd_mdu(Pd_mdu),
    .Conf_mdu(Conf_mdu), .RegWr_mdu(RegWr_mdu), .tag_rob_mdu(tag_rob_mdu)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [5:0] pj, pk, pd;
    logic       rj, rk;
    logic [3:0] conf;
    logic       regwr;
    logic [5:0] rob;
  } m_ent_t;
  m_ent_t m_q[$];

  function automatic bit hit(input logic [5:0] t);
    for (int p = 0; p < 5; p++)
      if (ready_cdb[p] && RegWr_cdb[p] && Pd_cdb[p] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [29:0] exp_bundle();
    foreach (m_q[i])
      if (m_q[i].rj && m_q[i].rk)
        return {1'b1, m_q[i].pj, m_q[i].pk, m_q[i].pd, m_q[i].conf, m_q[i].regwr, m_q[i].rob};
    return '0;
  endfunction

  task automatic model_edge();
    int osz;
    int s;
    m_ent_t e;
    osz = m_q.size();
    s = -1;
    if (flush_back) begin
      m_q.delete();
      return;
    end
    foreach (m_q[i]) if (s < 0 && m_q[i].rj && m_q[i].rk) s = i;
    if (s >= 0) m_q.delete(s);
    foreach (m_q[i]) begin
      if (hit(m_q[i].pj)) m_q[i].rj = 1'b1;
      if (hit(m_q[i].pk)) m_q[i].rk = 1'b1;
    end
    if (enq_valid && osz < DEPTH) begin
      e.pj = enq_Pj; e.pk = enq_Pk; e.pd = enq_Pd;
      e.rj = enq_rdy_j | hit(enq_Pj);
      e.rk = enq_rdy_k | hit(enq_Pk);
      e.conf = enq_Conf; e.regwr = enq_RegWr; e.rob = enq_tag_rob;
      m_q.push_back(e);
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] act_bundle();
    return {ready_mdu, Pj_mdu, Pk_mdu, Pd_mdu, Conf_mdu, RegWr_mdu, tag_rob_mdu};
  endfunction

  // Called at negedge+1 with inputs already applied; advances one clock.
  task automatic cycle();
    chk("model_bundle", 32'(act_bundle()), 32'(exp_bundle()));
    chk("model_full", 32'(full_iq), 32'(m_q.size() == DEPTH));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    enq_valid = 0; enq_Pj = 0; enq_Pk = 0; enq_Pd = 0; enq_rdy_j = 0; enq_rdy_k = 0;
    enq_Conf = 0; enq_RegWr = 0; enq_tag_rob = 0; flush_back = 0;
    ready_cdb = '0; RegWr_cdb = '0; Pd_cdb = '0;
  endtask

  task automatic enq(input logic [5:0] pj, input logic rj, input logic [5:0] pk, input logic rk,
                     input logic [5:0] pd, input logic [3:0] conf, input logic [5:0] rob);
    enq_valid = 1; enq_Pj = pj; enq_rdy_j = rj; enq_Pk = pk; enq_rdy_k = rk;
    enq_Pd = pd; enq_Conf = conf; enq_RegWr = 1; enq_tag_rob = rob;
  endtask

  task automatic bcast(input int p, input logic [5:0] tag);
    ready_cdb[p] = 1'b1; RegWr_cdb[p] = 1'b1; Pd_cdb[p] = tag;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic en; logic [5:0] pj; logic rj; logic [5:0] pk; logic rk; logic [5:0] pd;
    logic [3:0] conf; logic [5:0] rob;
    logic cv, cw; int cport; logic [5:0] ctag;
    logic x_rdy; logic [5:0] x_pd, x_rob; logic x_full;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic en, input logic [5:0] pj, input logic rj,
                              input logic [5:0] pk, input logic rk, input logic [5:0] pd,
                              input logic [3:0] conf, input logic [5:0] rob,
                              input logic cv, input logic cw, input int cport,
                              input logic [5:0] ctag, input logic xr,
                              input logic [5:0] xpd, input logic [5:0] xrob);
    vec_t v;
    v.en = en; v.pj = pj; v.rj = rj; v.pk = pk; v.rk = rk; v.pd = pd; v.conf = conf;
    v.rob = rob; v.cv = cv; v.cw = cw; v.cport = cport; v.ctag = ctag;
    v.x_rdy = xr; v.x_pd = xpd; v.x_rob = xrob; v.x_full = 1'b0;
    return v;
  endfunction

  function automatic vec_t idl(input logic xr, input logic [5:0] xpd, input logic [5:0] xrob);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, xr, xpd, xrob);
  endfunction

  function automatic vec_t cdb(input logic cv, input logic cw, input int p, input logic [5:0] t);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, cv, cw, p, t, 0, 0, 0);
  endfunction

  int exp_order[7] = '{40, 41, 42, 44, 45, 46, 47};

  initial begin
    // simple issue
    tbl.push_back(mk(1, 3, 1, 4, 1, 9, 2, 5, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idl(1, 9, 5));
    tbl.push_back(idl(0, 0, 0));
    // wakeup and age order
    tbl.push_back(mk(1, 7, 0, 1, 1, 10, 1, 6, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 2, 1, 2, 1, 11, 3, 7, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idl(1, 11, 7));
    tbl.push_back(cdb(1, 1, 2, 7));
    tbl.push_back(idl(1, 10, 6));
    tbl.push_back(idl(0, 0, 0));
    // same-cycle enqueue wakeup
    tbl.push_back(mk(1, 1, 1, 12, 0, 13, 4, 8, 1, 1, 4, 12, 0, 0, 0));
    tbl.push_back(idl(1, 13, 8));
    tbl.push_back(idl(0, 0, 0));
    // ignored broadcasts
    tbl.push_back(mk(1, 20, 0, 1, 1, 14, 5, 9, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(cdb(1, 0, 1, 20));
    tbl.push_back(cdb(0, 1, 3, 20));
    tbl.push_back(idl(0, 0, 0));
    tbl.push_back(cdb(1, 1, 0, 20));
    tbl.push_back(idl(1, 14, 9));
    tbl.push_back(idl(0, 0, 0));

    idle_in();
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_bundle", 32'(act_bundle()), 32'h0);
    chk("reset_full", 32'(full_iq), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[n]) begin
      idle_in();
      enq_valid = tbl[n].en; enq_Pj = tbl[n].pj; enq_rdy_j = tbl[n].rj;
      enq_Pk = tbl[n].pk; enq_rdy_k = tbl[n].rk; enq_Pd = tbl[n].pd;
      enq_Conf = tbl[n].conf; enq_RegWr = tbl[n].en; enq_tag_rob = tbl[n].rob;
      ready_cdb[tbl[n].cport] = tbl[n].cv; RegWr_cdb[tbl[n].cport] = tbl[n].cw;
      Pd_cdb[tbl[n].cport] = tbl[n].ctag;
      #1;
      chk($sformatf("tbl%0d_rdy", n), 32'(ready_mdu), 32'(tbl[n].x_rdy));
      chk($sformatf("tbl%0d_pd", n), 32'(Pd_mdu), 32'(tbl[n].x_pd));
      chk($sformatf("tbl%0d_rob", n), 32'(tag_rob_mdu), 32'(tbl[n].x_rob));
      chk($sformatf("tbl%0d_full", n), 32'(full_iq), 32'(tbl[n].x_full));
      cycle();
    end

    // full queue: drop, then issue from the middle and collapse
    for (int i = 0; i < 8; i++) begin
      idle_in(); enq(6'(30 + i), 0, 1, 1, 6'(40 + i), 4'(i), 6'(i)); #1; cycle();
    end
    idle_in(); enq(5, 1, 6, 1, 63, 15, 63); #1;
    chk("full_set", 32'(full_iq), 32'h1);
    cycle();
    idle_in(); bcast(0, 33); #1;
    chk("full_after_drop", 32'(full_iq), 32'h1);
    chk("drop_no_issue", 32'(ready_mdu), 32'h0);
    cycle();
    idle_in(); #1;
    chk("mid_issue_pd", 32'(Pd_mdu), 32'd43);
    chk("mid_issue_rdy", 32'(ready_mdu), 32'h1);
    cycle();
    idle_in(); bcast(0, 30); bcast(1, 31); bcast(2, 32); bcast(3, 34); bcast(4, 35); #1;
    chk("full_clear", 32'(full_iq), 32'h0);
    cycle();
    for (int k = 0; k < 7; k++) begin
      idle_in();
      if (k == 0) begin bcast(0, 36); bcast(1, 37); end
      #1;
      chk($sformatf("drain%0d_rdy", k), 32'(ready_mdu), 32'h1);
      chk($sformatf("drain%0d_pd", k), 32'(Pd_mdu), 32'(exp_order[k]));
      cycle();
    end
    idle_in(); #1;
    chk("drained", 32'(ready_mdu), 32'h0);
    cycle();

    // flush with concurrent enqueue and wakeup
    for (int i = 0; i < 5; i++) begin
      idle_in(); enq(6'(50 + i), 0, 1, 1, 6'(20 + i), 1, 6'(10 + i)); #1; cycle();
    end
    idle_in(); enq(1, 1, 1, 1, 61, 2, 30); bcast(0, 50); flush_back = 1; #1; cycle();
    idle_in(); for (int p = 0; p < 5; p++) bcast(p, 6'(50 + p)); #1;
    chk("flush_rdy", 32'(ready_mdu), 32'h0);
    chk("flush_full", 32'(full_iq), 32'h0);
    cycle();
    idle_in(); enq(2, 1, 3, 1, 60, 6, 33); #1;
    chk("flush_stale_wake", 32'(ready_mdu), 32'h0);
    cycle();
    idle_in(); #1;
    chk("post_flush_pd", 32'(Pd_mdu), 32'd60);
    cycle();

    // asynchronous reset mid-stream
    idle_in(); enq(4, 1, 5, 1, 62, 7, 44); #1; cycle();
    idle_in(); #1;
    chk("pre_rst_rdy", 32'(ready_mdu), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_bundle", 32'(act_bundle()), 32'h0);
    chk("async_rst_full", 32'(full_iq), 32'h0);
    m_q.delete();
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int c = 0; c < 500; c++) begin
      idle_in();
      enq_valid   = ($urandom_range(0, 9) < 6);
      enq_Pj      = 6'($urandom_range(0, 15));
      enq_Pk      = 6'($urandom_range(0, 15));
      enq_Pd      = 6'($urandom_range(0, 63));
      enq_rdy_j   = ($urandom_range(0, 9) < 3);
      enq_rdy_k   = ($urandom_range(0, 9) < 3);
      enq_Conf    = 4'($urandom_range(0, 15));
      enq_RegWr   = 1'($urandom_range(0, 1));
      enq_tag_rob = 6'($urandom_range(0, 63));
      for (int p = 0; p < 5; p++) begin
        ready_cdb[p] = ($urandom_range(0, 9) < 3);
        RegWr_cdb[p] = ($urandom_range(0, 9) < 7);
        Pd_cdb[p]    = 6'($urandom_range(0, 15));
      end
      flush_back = ($urandom_range(0, 59) == 0);
      #1;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iq_mdu.md
# iq_mdu

Out-of-order issue queue for the multiply/divide pipe. It sits directly upstream of the back end's MDU read port. It holds renamed MDU micro-ops until both source physical registers are produced, snooping the 5-port CDB for wakeups. Each cycle it issues the oldest ready entry as the `ready_mdu / Pj_mdu / Pk_mdu / Pd_mdu / Conf_mdu / RegWr_mdu / tag_rob_mdu` bundle.

## Interface
Parameters:
- `DEPTH`, 8: number of queue entries (≥2).
- `CNT_W`, `$clog2(DEPTH+1)`: occupancy counter width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `flush_back`  in  1: synchronous flush (mispredict or exception).
- `enq_valid`  in  1: dispatch presents a micro-op.
- `enq_Pj`, `enq_Pk`, `enq_Pd`  in  6 each: physical source and destination tags.
- `enq_rdy_j`, `enq_rdy_k`  in  1 each: operand-ready bits from the rename busy table.
- `enq_Conf`  in  4: MDU opcode config.
- `enq_RegWr`  in  1: writes a destination register.
- `enq_tag_rob`  in  6: ROB index.
- `full_iq`  out  1: `count == DEPTH`.
- `ready_cdb`, `RegWr_cdb`  in  1 x [4:0]: CDB broadcast valid and write-enable.
- `Pd_cdb`  in  6 x [4:0]: CDB destination tags.
- `ready_mdu`  out  1: issue valid.
- `Pj_mdu`, `Pk_mdu`, `Pd_mdu`  out  6 each: issued tags.
- `Conf_mdu`  out  4: issued opcode config.
- `RegWr_mdu`  out  1: issued write-enable.
- `tag_rob_mdu`  out  6: issued ROB index.

## Operation
- Storage is a collapsing queue. Slot 0 is the oldest entry; slots `[0, count)` are valid. Each entry holds `Pj, Pk, Pd, rdy_j, rdy_k, Conf, RegWr, tag_rob`.
- **Wakeup.**
  - A CDB port `i` hits when `ready_cdb[i] & RegWr_cdb[i]`.
  - For each valid entry, `rdy_j` is set at the next edge if `Pj` equals any hit `Pd_cdb[i]`; `rdy_k` likewise.
  - Ready bits never clear except by dequeue or flush.
- **Enqueue wakeup.** A micro-op enqueued in the same cycle as a matching CDB hit stores `rdy=1`, so a broadcast is never lost.
- **Select.** The lowest-index valid entry with `rdy_j & rdy_k` is selected. The output bundle is driven combinationally from that entry. `ready_mdu = 1` iff a selected entry exists. With no selection, tag, config and flag outputs are 0.
- **Dequeue.** The selected entry is removed at the edge. Entries above it shift down by one, keeping age order. Wakeups are applied to the shifted copies in the same edge.
- **Enqueue.** Accepted iff `enq_valid & ~full_iq & ~flush_back`. The entry is written at slot `count - issued` (post-shift tail).
- **Occupancy.** `count_next = count + enq_accept - issued`.
- **Full.** `full_iq` is from registered `count` only. A full queue refuses enqueue even when it issues in the same cycle.
- **Dispatch rule.** Dispatch must not assert `enq_valid` while `full_iq` is high. If it does, the request is dropped and state is unchanged.
- **Flush.** `flush_back` clears `count` and all valid slots at the next edge. Same-cycle enqueue, wakeup and issue have no effect on state. `ready_mdu` may still be high during the flush cycle; the downstream read register discards it because it is flushed by the same signal.
- **Reset.** Asynchronous. `count = 0` and all entry fields are 0. While `rst` is high: `ready_mdu = 0`, `full_iq = 0`, all tag/config outputs 0.

## Timing
- **Enqueue to issue.**
  - Entry enqueued with both ready bits at edge t: `ready_mdu` high in cycle t+1 at the earliest.
  - Entry woken by a CDB hit in cycle t: eligible for issue in cycle t+1. A CDB hit never causes issue in the same cycle.
- **Throughput.** One issue and one enqueue per cycle, sustained.
- **Issue handshake.** There is no downstream stall. An asserted `ready_mdu` is consumed unconditionally at the edge.
- **Wakeup filtering.** A CDB broadcast with `RegWr_cdb = 0` or `ready_cdb = 0` never wakes an entry.

## Test plan
- **Reset and simple issue.** Reset, then enqueue `Pj=3, Pk=4, Pd=9, rdy_j=rdy_k=1, tag_rob=5, Conf=2`.
  - Cycle +1: `ready_mdu=1`, `Pd_mdu=9`, `tag_rob_mdu=5`.
  - Cycle +2: `ready_mdu=0`, `count=0`.
- **Wakeup and age order.**
  - Enqueue A (`Pj=7` not ready), then B (both ready).
  - B issues first.
  - CDB port 2 broadcasts `Pd=7, RegWr=1` at cycle t: A issues at t+1, not at t.
- **Same-cycle enqueue wakeup.** Enqueue `Pk=12, rdy_k=0` while `ready_cdb[4]=1, RegWr_cdb[4]=1, Pd_cdb[4]=12` -> entry issues the next cycle.
- **Full.** Fill 8 non-ready entries -> `full_iq=1`; a further `enq_valid` is dropped and `count` stays 8. Then wake slot 3 -> it issues, slots 4..7 shift to 3..6, `count=7`, `full_iq=0` the next cycle.
- **Flush mid-operation.** With 5 entries and a concurrent enqueue and CDB hit, assert `flush_back` -> next cycle `count=0`, `ready_mdu=0`, `full_iq=0`; a later CDB hit on an old tag issues nothing.
- **Ignored broadcast.** A CDB hit with `RegWr_cdb=0` on a matching tag -> no wakeup and no issue; asserting `rst` mid-stream drives all outputs to 0 immediately.
